passgate_bus_arbiter: RTL
=========================

# passgate_bus_arbiter

Round-robin arbiter that shares one switch-level bus net between N drivers, each connected through an nmos/pmos pass-gate pair. Produces one-hot gate controls: `nctrl` for the nmos gates (active-high) and `pctrl` for the pmos gates (active-low, always `~nctrl`). Guarantees break-before-make: there are at least `DEAD` all-off cycles between any two owners, so two pass gates never drive the net together. Sits between requester logic and the switch-level `nmos`/`pmos` primitive instances in the bus wrapper.

## Interface
- `N`, default 4: number of requesters/pass-gate pairs; legal range 2..16.
- `DEAD`, default 2: break-before-make cycles between owners; must be ≥1.
- `MAXHOLD`, default 8: maximum cycles one owner keeps the bus; 0 = unlimited.

- `clk` input 1: single clock; all logic on the rising edge.
- `rstn` input 1: reset, synchronous and active-low.
- `req` input N: level request per driver; held high while the driver wants the bus.
- `gnt` output N: one-hot grant (or all-zero); registered.
- `nctrl` output N: nmos gate controls; equal to `gnt`.
- `pctrl` output N: pmos gate controls; equal to `~gnt`.
- `busy` output 1: high in state ON.
- `dead` output 1: high in state DEAD.

## Operation
- FSM has three states: IDLE, ON, DEAD. The FSM, `owner`, round-robin pointer `ptr`, hold counter and dead counter are all registered.
- IDLE:
  - If `req != 0`, select the first set bit searching `ptr, ptr+1, …` modulo N.
  - Load `owner`, set `gnt = 1<<owner`, go to ON, clear the hold counter.
- ON:
  - `gnt` holds one-hot at `owner`; the hold counter increments every cycle.
  - Release when `req[owner]==0`, or when `MAXHOLD!=0` and the counter reaches `MAXHOLD-1`.
  - On release: `gnt` goes to 0, `ptr` becomes `owner+1` mod N, go to DEAD with the dead counter loaded to `DEAD-1`.
- DEAD:
  - `gnt` stays 0; the dead counter decrements.
  - At 0, arbitrate exactly as IDLE does. If any `req` is set, go straight to ON; otherwise go to IDLE.
- Requests from non-owners during ON or DEAD are not latched. Only the `req` level at the arbitration cycle matters.
- A preempted owner that keeps `req` high is re-served only after all other active requesters have been served (via the pointer rotation).
- Invariant: `nctrl` has popcount ≤1, and `pctrl == ~nctrl` on every cycle including reset.

## Timing
- Reset (`rstn` low at an edge) gives: `gnt=0`, `nctrl=0`, `pctrl` all ones, `busy=0`, `dead=0`, `ptr=0`, state IDLE.
- Reset asserted during ON turns all switches off at that edge. There is no dead phase after reset; the first grant comes at least 1 cycle after `rstn` rises.
- Grant latency:
  - `req` sampled high at edge k in IDLE → `gnt` high after edge k.
  - Released at edge k → `gnt=0` after edge k; the next grant is visible after edge k+DEAD at the earliest.
- Hold: with `MAXHOLD=M` and `req` held, `gnt` is high for exactly M cycles.
- `req[owner]` falling at edge k → `gnt` low after edge k, i.e. one cycle of grant after the request drops is not allowed to extend.
- Pointer wrap: `owner=N-1` sets `ptr=0`.

## Structure
- Shared package `passgate_pkg`:
  - state encoding constants `ST_IDLE=2'd0`, `ST_ON=2'd1`, `ST_DEAD=2'd2`;
  - function `rr_pick(req, ptr)` returning an index plus a valid flag.
- Optional sub-module `rr_picker`: a combinational rotate/priority-encode/unrotate over N bits. It is the only natural split; everything else stays in `passgate_bus_arbiter`.
- Bus wrapper instantiates N `nmos`/`pmos` pairs fed by `nctrl`/`pctrl`. That wrapper is out of scope.

## Test plan
- Reset with `req=4'b1111` held through reset → `gnt=0`, `pctrl=4'b1111` during reset; `gnt=4'b0001` 1 cycle after `rstn` rises.
- Single requester, `req=4'b0100` for 3 cycles then dropped → `gnt=4'b0100` for 3 cycles; `dead=1` for 2 cycles; then IDLE with `gnt=0`.
- All requesting, `MAXHOLD=8`, `DEAD=2`, `req=4'b1111` held → grant sequence 0001, 0010, 0100, 1000, 0001. Each grant lasts 8 cycles, separated by 2 zero cycles.
- Wrap and fairness: `ptr=3`, `req=4'b1001` → owner 3 first, then owner 0. Owner 3 re-requesting while 0 also requests does not get the bus twice in a row.
- Reset during ON with `owner=2` → `nctrl=0`, `pctrl=4'b1111` at the next edge; `ptr=0` afterward.
- Random `req` for 10k cycles with checker assertions: popcount(`nctrl`) ≤1; `pctrl==~nctrl`; ≥`DEAD` zero cycles between differing grants; no grant longer than `MAXHOLD`.

Source files
------------

// File: rtl/passgate_bus_arbiter_pkg.sv
// passgate_pkg: state encoding and round-robin pick helper shared by the pass-gate arbiter
package passgate_pkg;
    localparam int MAXN = 16;
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ON = 2'd1, ST_DEAD = 2'd2} state_t;
    typedef struct packed {
        logic       valid;
        logic [3:0] idx;
    } pick_t;
    // Walk downward so the candidate closest to ptr is written last and wins
    function automatic pick_t rr_pick(input logic [MAXN-1:0] req, input logic [3:0] ptr, input int n);
        pick_t p;
        int j;
        p = '0;
        for (int i = MAXN - 1; i >= 0; i--) begin
            j = (int'(ptr) + i) % n;
            if (i < n && req[j[3:0]]) begin
                p.valid = 1'b1;
                p.idx = j[3:0];
            end
        end
        return p;
    endfunction
endpackage

// File: rtl/passgate_bus_arbiter_if.sv
// passgate_bus_arbiter_if: request/grant and pass-gate control bundle
interface passgate_bus_arbiter_if #(parameter int N = 4);
    logic [N-1:0] req, gnt, nctrl, pctrl;
    logic busy, dead;
    modport master (input req, output gnt, nctrl, pctrl, busy, dead);
    modport slave (output req, input gnt, nctrl, pctrl, busy, dead);
endinterface

// File: rtl/passgate_bus_arbiter_picker.sv
// rr_picker: first set request at or after ptr, searching upward modulo N
module rr_picker import passgate_pkg::*; #(parameter int N = 4) (
    input  logic [N-1:0] req,
    input  logic [3:0]   ptr,
    output logic         valid,
    output logic [3:0]   idx
);
    pick_t p;
    assign p = rr_pick(MAXN'(req), ptr, N);
    assign valid = p.valid;
    assign idx = p.idx;
endmodule

// File: rtl/passgate_bus_arbiter.sv
// passgate_bus_arbiter: round-robin owner select for a shared pass-gate net with break-before-make gaps
module passgate_bus_arbiter import passgate_pkg::*; #(
    parameter int N = 4,
    parameter int DEAD = 2,
    parameter int MAXHOLD = 8
) (
    input logic clk,
    input logic rstn,
    passgate_bus_arbiter_if.master bus
);
    localparam int IW = $clog2(N);
    state_t state;
    logic [IW-1:0] owner, ptr;
    logic [N-1:0] gnt;
    logic [31:0] hcnt, dcnt;
    logic pick_valid, arb, rel;
    logic [3:0] pick_idx;
    rr_picker #(.N(N)) u_pick (.req(bus.req), .ptr(4'(ptr)), .valid(pick_valid), .idx(pick_idx));
    assign arb = state == ST_IDLE || (state == ST_DEAD && dcnt == 0);
    assign rel = !bus.req[owner] || (MAXHOLD != 0 && hcnt == 32'(MAXHOLD - 1));
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= ST_IDLE;
            owner <= '0;
            ptr <= '0;
            gnt <= '0;
            hcnt <= '0;
            dcnt <= '0;
        end else if (arb) begin
            state <= pick_valid ? ST_ON : ST_IDLE;
            owner <= pick_valid ? pick_idx[IW-1:0] : owner;
            gnt <= pick_valid ? N'(1) << pick_idx : '0;
            hcnt <= '0;
        end else if (state == ST_ON) begin
            if (rel) begin
                state <= ST_DEAD;
                gnt <= '0;
                ptr <= owner == IW'(N - 1) ? '0 : owner + 1'b1;
                dcnt <= 32'(DEAD - 1);
            end else begin
                hcnt <= hcnt + 1;
            end
        end else begin
            dcnt <= dcnt - 1;
        end
    end
    assign bus.gnt = gnt;
    assign bus.nctrl = gnt;
    assign bus.pctrl = ~gnt;
    assign bus.busy = state == ST_ON;
    assign bus.dead = state == ST_DEAD;
endmodule
